// File: rtl/fp_add_result_normalizer.sv
// fp_add_result_normalizer
// Post-add renormalization stage of the single-precision FP adder.
// It accepts a raw mantissa sum together with its shared exponent and finds
// the leading one. It then shifts the sum and adjusts the exponent, and packs
// the result as an IEEE-754 single.
// The IDLE state resolves special, zero, carry-out and already-normalized sums
// directly. Sums with leading zeros go through the SHIFT state.
// Optional build macro: FP_NORM_LZC_EN. When it is defined, SHIFT uses a
// leading-zero count and finishes in one cycle. When it is undefined, SHIFT
// moves the sum left by one bit per cycle.
module fp_add_result_normalizer #(
    parameter int EXP_W  = 8,
    parameter int SUM_W  = 24,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [SUM_W-1:0]        in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_zero,
    output logic                    out_overflow,
    output logic                    out_underflow
);

    // Bit index of the hidden one. The carry bit sits one position above it.
    localparam int HID   = SUM_W - 2;
    localparam int RES_W = EXP_W + FRAC_W + 1;

    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [SUM_W-1:0] SUM_ZERO = {SUM_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               sign_reg, sign_next;
    logic [EXP_W-1:0]   exp_reg, exp_next;
    logic [HID:0]       mant_reg, mant_next;
    logic               out_valid_reg, out_valid_next;
    logic [RES_W-1:0]   result_reg, result_next;
    logic               zero_reg, zero_next;
    logic               overflow_reg, overflow_next;
    logic               underflow_reg, underflow_next;

    logic [EXP_W-1:0]   exp_inc;
    logic [HID:0]       mant_carry;

    // Pack the sign, exponent and normalized mantissa.
    // The aligner drops the LSB of the sum, so the lowest fraction bit is
    // always zero.
    function automatic logic [RES_W-1:0] pack(input logic             s,
                                              input logic [EXP_W-1:0] e,
                                              input logic [HID:0]     m);
        pack = {s, e, m[HID-1:0], {(FRAC_W-HID){1'b0}}};
    endfunction

    // A saturated result: an infinity that keeps the sign.
    function automatic logic [RES_W-1:0] pack_inf(input logic s);
        pack_inf = {s, EXP_MAX, {FRAC_W{1'b0}}};
    endfunction

    assign exp_inc    = in_exp + EXP_ONE;
    assign mant_carry = in_mant[SUM_W-1:1];

`ifdef FP_NORM_LZC_EN
    localparam int LZC_W = $clog2(SUM_W);

    logic [HID:0]       zero_above;
    logic [LZC_W-1:0]   lzc;
    logic [EXP_W-1:0]   lzc_ext;
    logic [HID:0]       mant_norm;

    // zero_above[gi] is set when no bit from gi up to the hidden position is set.
    // The number of such positions is the leading-zero count.
    genvar gi;
    generate
        for (gi = 0; gi <= HID; gi++) begin : g_zero_above
            assign zero_above[gi] = ~|mant_reg[HID:gi];
        end
    endgenerate

    // Count the leading zeros by summing the zero_above flags.
    always_comb begin
        lzc = '0;
        for (int i = 0; i <= HID; i++) begin
            lzc = lzc + LZC_W'(zero_above[i]);
        end
    end

    assign lzc_ext   = {{(EXP_W-LZC_W){1'b0}}, lzc};
    assign mant_norm = mant_reg << lzc;
`else
    logic [HID:0]       mant_shl;

    assign mant_shl = {mant_reg[HID-1:0], 1'b0};
`endif

    // Compute the next state, the operand registers and the packed result.
    always_comb begin
        state_next     = state_reg;
        sign_next      = sign_reg;
        exp_next       = exp_reg;
        mant_next      = mant_reg;
        out_valid_next = out_valid_reg;
        result_next    = result_reg;
        zero_next      = zero_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sign_next = in_sign;
                    exp_next  = in_exp;
                    mant_next = in_mant[HID:0];
                    if (in_exp == EXP_MAX) begin
                        result_next    = pack_inf(in_sign);
                        overflow_next  = 1'b1;
                        out_valid_next = 1'b1;
                        state_next     = DONE;
                    end else if (in_mant == SUM_ZERO) begin
                        // An exact zero sum always gives +0.
                        result_next    = '0;
                        zero_next      = 1'b1;
                        out_valid_next = 1'b1;
                        state_next     = DONE;
                    end else if (in_mant[SUM_W-1]) begin
                        // Carry out: shift right by one and drop the LSB.
                        mant_next = mant_carry;
                        exp_next  = exp_inc;
                        if (exp_inc == EXP_MAX) begin
                            result_next   = pack_inf(in_sign);
                            overflow_next = 1'b1;
                        end else begin
                            result_next   = pack(in_sign, exp_inc, mant_carry);
                        end
                        out_valid_next = 1'b1;
                        state_next     = DONE;
                    end else if (in_mant[HID]) begin
                        result_next    = pack(in_sign, in_exp, in_mant[HID:0]);
                        out_valid_next = 1'b1;
                        state_next     = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end

            SHIFT: begin
`ifdef FP_NORM_LZC_EN
                // Flush whenever normalizing would take the exponent below 1,
                // so that this path gives the same results as the serial path.
                if (lzc_ext >= exp_reg) begin
                    result_next    = {sign_reg, {(RES_W-1){1'b0}}};
                    underflow_next = 1'b1;
                    zero_next      = 1'b1;
                end else begin
                    mant_next   = mant_norm;
                    exp_next    = exp_reg - lzc_ext;
                    result_next = pack(sign_reg, exp_reg - lzc_ext, mant_norm);
                end
                out_valid_next = 1'b1;
                state_next     = DONE;
`else
                // An exponent of 1 cannot be decremented further.
                // An entry exponent of 0 gets the same treatment so that the
                // exponent never wraps around.
                if ((exp_reg <= EXP_ONE) && !mant_reg[HID]) begin
                    result_next    = {sign_reg, {(RES_W-1){1'b0}}};
                    underflow_next = 1'b1;
                    zero_next      = 1'b1;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end else begin
                    mant_next = mant_shl;
                    exp_next  = exp_reg - EXP_ONE;
                    if (mant_shl[HID]) begin
                        result_next    = pack(sign_reg, exp_reg - EXP_ONE, mant_shl);
                        out_valid_next = 1'b1;
                        state_next     = DONE;
                    end
                end
`endif
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    zero_next      = 1'b0;
                    overflow_next  = 1'b0;
                    underflow_next = 1'b0;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers, with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sign_reg      <= 1'b0;
            exp_reg       <= '0;
            mant_reg      <= '0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sign_reg      <= sign_next;
            exp_reg       <= exp_next;
            mant_reg      <= mant_next;
            out_valid_reg <= out_valid_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign in_ready      = (state_reg == IDLE);
    assign out_valid     = out_valid_reg;
    assign out_result    = result_reg;
    assign out_zero      = zero_reg;
    assign out_overflow  = overflow_reg;
    assign out_underflow = underflow_reg;

endmodule

// File: tb/tb_fp_add_result_normalizer.sv
// Testbench for fp_add_result_normalizer: directed vectors with hand-computed
// results, plus sequences for backpressure and reset during SHIFT.
module tb_fp_add_result_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [23:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_underflow;

    int errors = 0;
    int checks = 0;

`ifdef FP_NORM_LZC_EN
    localparam bit LZC_BUILD = 1'b1;
`else
    localparam bit LZC_BUILD = 1'b0;
`endif

    fp_add_result_normalizer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The flags are packed as {zero, overflow, underflow}.
    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic [31:0] res;
        logic [2:0]  flags;
        int          lat_ser;
        int          lat_lzc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Wait for in_ready, present one operand and return just after the accept edge.
    task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_send", {31'b0, in_ready}, 32'd1);
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency is 1 when out_valid is already high just after the accept edge.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {29'b0, out_zero, out_overflow, out_underflow};
    endfunction

    initial begin
        int lat;
        int req_lat;

        vecs[0]  = '{1'b0, 8'h7F, 24'h400000, 32'h3F800000, 3'b000,  1, 1};
        vecs[1]  = '{1'b0, 8'h7F, 24'h800000, 32'h40000000, 3'b000,  1, 1};
        vecs[2]  = '{1'b0, 8'hFE, 24'h800000, 32'h7F800000, 3'b010,  1, 1};
        vecs[3]  = '{1'b0, 8'h7F, 24'h000001, 32'h34800000, 3'b000, 23, 2};
        vecs[4]  = '{1'b1, 8'h05, 24'h000001, 32'h80000000, 3'b101,  6, 2};
        vecs[5]  = '{1'b1, 8'h7F, 24'h000000, 32'h00000000, 3'b100,  1, 1};
        vecs[6]  = '{1'b1, 8'hFF, 24'h412345, 32'hFF800000, 3'b010,  1, 1};
        vecs[7]  = '{1'b1, 8'h80, 24'h600000, 32'hC0400000, 3'b000,  1, 1};
        vecs[8]  = '{1'b0, 8'h10, 24'h200001, 32'h07800004, 3'b000,  2, 2};
        vecs[9]  = '{1'b0, 8'h7F, 24'hC00003, 32'h40400002, 3'b000,  1, 1};
        vecs[10] = '{1'b0, 8'h02, 24'h200000, 32'h00800000, 3'b000,  2, 2};
        vecs[11] = '{1'b0, 8'h01, 24'h200000, 32'h00000000, 3'b101,  2, 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'h00;
        in_mant   = 24'h0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid",  {31'b0, out_valid}, 32'd0);
        check("reset_out_result", out_result, 32'h0);
        check("reset_flags",      flags_now(), 32'd0);
        check("reset_in_ready",   {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Apply each table vector, then complete the output handshake.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].s, vecs[i].e, vecs[i].m);
            wait_valid(lat);
            req_lat = LZC_BUILD ? vecs[i].lat_lzc : vecs[i].lat_ser;
            check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("vec%0d_result", i), out_result, vecs[i].res);
            check($sformatf("vec%0d_flags", i), flags_now(), {29'b0, vecs[i].flags});
            check($sformatf("vec%0d_latency", i), lat, req_lat);
            check($sformatf("vec%0d_in_ready_busy", i), {31'b0, in_ready}, 32'd0);
            $display("vec%0d: s=%0b e=%h m=%h -> result=%h flags=%03b lat=%0d",
                     i, vecs[i].s, vecs[i].e, vecs[i].m, out_result, flags_now(), lat);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check($sformatf("vec%0d_valid_drop", i), {31'b0, out_valid}, 32'd0);
            check($sformatf("vec%0d_flags_clear", i), flags_now(), 32'd0);
        end

        // Backpressure: the result must hold for five cycles in DONE.
        send(1'b0, 8'h7F, 24'h400000);
        wait_valid(lat);
        check("bp_latency", lat, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_result_hold", out_result, 32'h3F800000);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_valid_drop", {31'b0, out_valid}, 32'd0);
        check("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
        $display("backpressure: result held %h, released", out_result);

        // Reset on the third SHIFT cycle of a deep renormalization.
        send(1'b0, 8'h7F, 24'h000001);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_out_result", out_result, 32'h0);
        check("rst_mid_flags", flags_now(), 32'd0);
        check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset mid-op: out_valid=%0b out_result=%h", out_valid, out_result);

        send(1'b0, 8'h7F, 24'h400000);
        wait_valid(lat);
        check("post_rst_latency", lat, 1);
        check("post_rst_result", out_result, 32'h3F800000);
        check("post_rst_flags", flags_now(), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("post-reset accept: result=%h lat=%0d", out_result, lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
